// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM row controller: FSM encoding, default phase
// lengths and the per-state decode of the array strobes.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StWl,
        StSense,
        StDone
    } state_e;

    localparam int unsigned DefTPre = 2;
    localparam int unsigned DefTWl  = 3;
    localparam int unsigned DefTSa  = 1;
    localparam int unsigned CntW    = 4;

    typedef struct packed {
        logic pre_n;
        logic wl_en;
        logic sae;
        logic wr_en;
        logic busy;
    } strobes_t;

    // Counter load value on phase entry; the phase ends when the count reaches zero.
    function automatic logic [CntW-1:0] phase_load(int unsigned len);
        return CntW'(len - 1);
    endfunction

    function automatic strobes_t phase_strobes(state_e st, logic we);
        strobes_t s;
        s.pre_n = (st != StPre);
        s.wl_en = (st == StWl) || (st == StSense);
        s.sae   = (st == StSense);
        s.wr_en = (st == StWl) && we;
        s.busy  = (st != StIdle);
        return s;
    endfunction

endpackage

// File: rtl/sram_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not served last wins.
module sram_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic take,
    output logic sel_b,
    output logic any
);

    logic prio_b_q;

    always_comb begin
        any   = req_a || req_b;
        sel_b = req_b && (!req_a || prio_b_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_b_q <= 1'b0;
        end else if (take) begin
            prio_b_q <= !sel_b;
        end
    end

endmodule

// File: rtl/sram_row_ctrl.sv
// SRAM row access sequencer: precharge, wordline, sense and done phases for two
// requesters sharing one array; all array strobes are registered.
module sram_row_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned T_PRE = DefTPre,
    parameter int unsigned T_WL  = DefTWl,
    parameter int unsigned T_SA  = DefTSa
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       we_a,
    input  logic       we_b,
    input  logic [5:0] addr_a,
    input  logic [5:0] addr_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       done_a,
    output logic       done_b,
    output logic [5:0] dec_addr,
    output logic       wl_en,
    output logic       pre_n,
    output logic       sae,
    output logic       wr_en,
    output logic       busy
);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              owner_b_q, owner_b_d;
    logic              we_q, we_d;
    logic [5:0]        addr_q, addr_d;
    logic              arb_sel_b, arb_any, arb_take;
    strobes_t          strb_d;

    sram_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_a (req_a),
        .req_b (req_b),
        .take  (arb_take),
        .sel_b (arb_sel_b),
        .any   (arb_any)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_b_d = owner_b_q;
        we_d      = we_q;
        addr_d    = addr_q;
        arb_take  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Requests are only looked at here, so a dropped req mid-access is ignored.
                if (arb_any) begin
                    arb_take  = 1'b1;
                    state_d   = StPre;
                    cnt_d     = phase_load(T_PRE);
                    owner_b_d = arb_sel_b;
                    we_d      = arb_sel_b ? we_b : we_a;
                    addr_d    = arb_sel_b ? addr_b : addr_a;
                end
            end
            StPre: begin
                if (cnt_q == '0) begin
                    state_d = StWl;
                    cnt_d   = phase_load(T_WL);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWl: begin
                if (cnt_q == '0) begin
                    if (we_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StSense;
                        cnt_d   = phase_load(T_SA);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StSense: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        strb_d = phase_strobes(state_d, we_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            owner_b_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_b_q <= owner_b_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
        end
    end

    // Strobes are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_n  <= 1'b1;
            wl_en  <= 1'b0;
            sae    <= 1'b0;
            wr_en  <= 1'b0;
            busy   <= 1'b0;
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            done_a <= 1'b0;
            done_b <= 1'b0;
        end else begin
            pre_n  <= strb_d.pre_n;
            wl_en  <= strb_d.wl_en;
            sae    <= strb_d.sae;
            wr_en  <= strb_d.wr_en;
            busy   <= strb_d.busy;
            gnt_a  <= strb_d.busy && !owner_b_d;
            gnt_b  <= strb_d.busy && owner_b_d;
            done_a <= (state_d == StDone) && !owner_b_d;
            done_b <= (state_d == StDone) && owner_b_d;
        end
    end

    assign dec_addr = addr_q;

endmodule
